// File: rtl/cpu64_l2_pkg.sv
// Shared definitions for the CPU64 L2 cache blocks: line geometry defaults
// and the miss-service engine state encoding.
package cpu64_l2_pkg;

    localparam int L2_LINE_WORDS = 8;
    localparam int L2_TAG_W      = 50;
    localparam int L2_IDX_W      = 8;
    localparam int L2_OFFSET_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROBE   = 3'd1,
        ST_WB_REQ  = 3'd2,
        ST_WB_DATA = 3'd3,
        ST_RF_REQ  = 3'd4,
        ST_RF_DATA = 3'd5,
        ST_DONE    = 3'd6
    } l2_state_e;

endpackage

// File: rtl/cpu64_l2_line_engine.sv
// L2 miss-service engine: probes the victim way, writes back a dirty victim
// as an 8-beat burst, then refills the line from memory into the array.
module cpu64_l2_line_engine
    import cpu64_l2_pkg::*;
#(
    parameter int LINE_WORDS = L2_LINE_WORDS,
    parameter int TAG_W      = L2_TAG_W,
    parameter int IDX_W      = L2_IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [IDX_W-1:0] req_index_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic [3:0]       req_way_i,
    output logic             done_o,
    output logic             wb_done_o,
    output logic [IDX_W-1:0] arr_index_o,
    output logic [2:0]       arr_word_o,
    output logic [3:0]       arr_way_o,
    output logic             arr_we_o,
    output logic             arr_set_valid_o,
    output logic             arr_set_dirty_o,
    output logic [7:0]       arr_be_o,
    output logic [TAG_W-1:0] arr_tag_o,
    output logic [63:0]      arr_wdata_o,
    input  logic [63:0]      arr_rdata_i,
    input  logic [TAG_W-1:0] arr_tag_i,
    input  logic             arr_valid_i,
    input  logic             arr_dirty_i,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic             mem_req_we_o,
    output logic [63:0]      mem_req_addr_o,
    output logic             mem_wvalid_o,
    input  logic             mem_wready_i,
    output logic [63:0]      mem_wdata_o,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i
);

    localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

    l2_state_e        state_r;
    l2_state_e        next_state_s;
    logic [2:0]       cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [TAG_W-1:0] tag_r;
    logic [TAG_W-1:0] vtag_r;
    logic [3:0]       way_r;
    logic             wb_r;
    logic             wr_we_r;
    logic             wr_valid_r;
    logic [2:0]       wr_word_r;
    logic [63:0]      wr_data_r;
    logic             last_beat_s;

    assign last_beat_s = (cnt_r == LAST_BEAT);

    // Next-state decode; the beat counter never wraps, the last beat exits the burst.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) next_state_s = ST_PROBE;
                else             next_state_s = ST_IDLE;
            end
            ST_PROBE: begin
                if (arr_valid_i && arr_dirty_i) next_state_s = ST_WB_REQ;
                else                            next_state_s = ST_RF_REQ;
            end
            ST_WB_REQ: begin
                if (mem_req_ready_i) next_state_s = ST_WB_DATA;
                else                 next_state_s = ST_WB_REQ;
            end
            ST_WB_DATA: begin
                if (mem_wready_i && last_beat_s) next_state_s = ST_RF_REQ;
                else                             next_state_s = ST_WB_DATA;
            end
            ST_RF_REQ: begin
                if (mem_req_ready_i) next_state_s = ST_RF_DATA;
                else                 next_state_s = ST_RF_REQ;
            end
            ST_RF_DATA: begin
                if (mem_rvalid_i && last_beat_s) next_state_s = ST_DONE;
                else                             next_state_s = ST_RF_DATA;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_r <= ST_IDLE;
        else         state_r <= next_state_s;
    end

    // Request latches, beat counter and the registered array-write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r      <= 3'd0;
            idx_r      <= '0;
            tag_r      <= '0;
            vtag_r     <= '0;
            way_r      <= 4'd0;
            wb_r       <= 1'b0;
            wr_we_r    <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_word_r  <= 3'd0;
            wr_data_r  <= 64'd0;
        end else begin
            wr_we_r    <= 1'b0;
            wr_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        idx_r <= req_index_i;
                        tag_r <= req_tag_i;
                        way_r <= req_way_i;
                        wb_r  <= 1'b0;
                        cnt_r <= 3'd0;
                    end
                end
                ST_PROBE: begin
                    cnt_r <= 3'd0;
                    if (arr_valid_i && arr_dirty_i) begin
                        vtag_r <= arr_tag_i;
                        wb_r   <= 1'b1;
                    end
                end
                ST_WB_DATA: begin
                    if (mem_wready_i) cnt_r <= last_beat_s ? 3'd0 : cnt_r + 3'd1;
                end
                ST_RF_REQ: cnt_r <= 3'd0;
                ST_RF_DATA: begin
                    if (mem_rvalid_i) begin
                        wr_we_r    <= 1'b1;
                        // Only the final beat marks the line valid, so an abandoned refill stays invalid.
                        wr_valid_r <= last_beat_s;
                        wr_word_r  <= cnt_r;
                        wr_data_r  <= mem_rdata_i;
                        cnt_r      <= last_beat_s ? 3'd0 : cnt_r + 3'd1;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign req_ready_o     = (state_r == ST_IDLE);
    assign done_o          = (state_r == ST_DONE);
    assign wb_done_o       = (state_r == ST_DONE) && wb_r;

    assign arr_index_o     = idx_r;
    assign arr_way_o       = way_r;
    assign arr_word_o      = wr_we_r ? wr_word_r : cnt_r;
    assign arr_we_o        = wr_we_r;
    assign arr_set_valid_o = wr_valid_r;
    assign arr_set_dirty_o = 1'b0;
    assign arr_be_o        = wr_we_r ? 8'hFF : 8'h00;
    assign arr_tag_o       = tag_r;
    assign arr_wdata_o     = wr_data_r;

    assign mem_req_valid_o = (state_r == ST_WB_REQ) || (state_r == ST_RF_REQ);
    assign mem_req_we_o    = (state_r == ST_WB_REQ);
    assign mem_req_addr_o  = (state_r == ST_WB_REQ) ? 64'({vtag_r, idx_r, 6'b0}) :
                             (state_r == ST_RF_REQ) ? 64'({tag_r, idx_r, 6'b0})  : 64'd0;
    assign mem_wvalid_o    = (state_r == ST_WB_DATA);
    assign mem_wdata_o     = (state_r == ST_WB_DATA) ? arr_rdata_i : 64'd0;

endmodule

// File: tb/tb_cpu64_l2_line_engine.sv
// Directed bench for cpu64_l2_line_engine: a bench-side memory/array model
// drives each miss and records every array write, burst request and beat.
module tb_cpu64_l2_line_engine;

    localparam logic [63:0] ARR_BASE = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] RD_BASE  = 64'hBEEF_0000_0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [7:0]  req_index_i = 8'd0;
    logic [49:0] req_tag_i = 50'd0;
    logic [3:0]  req_way_i = 4'd0;
    logic        done_o, wb_done_o;
    logic [7:0]  arr_index_o;
    logic [2:0]  arr_word_o;
    logic [3:0]  arr_way_o;
    logic        arr_we_o, arr_set_valid_o, arr_set_dirty_o;
    logic [7:0]  arr_be_o;
    logic [49:0] arr_tag_o;
    logic [63:0] arr_wdata_o;
    logic [63:0] arr_rdata_i;
    logic [49:0] arr_tag_i = 50'd0;
    logic        arr_valid_i = 1'b0;
    logic        arr_dirty_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_req_we_o;
    logic [63:0] mem_req_addr_o;
    logic        mem_wvalid_o;
    logic        mem_wready_i = 1'b0;
    logic [63:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = 64'd0;

    int checks = 0;
    int failures = 0;

    // Recorded activity of the most recent miss.
    int          n_wr, n_wb, n_mreq, n_done, stalls;
    logic        done_wb, post_ok, stall_bad, timed_out;
    logic [2:0]  wr_word [16];
    logic [63:0] wr_data [16];
    logic        wr_sv [16];
    logic        wr_dirty [16];
    logic [49:0] wr_tag [16];
    logic [7:0]  wr_be [16];
    logic [7:0]  wr_idx [16];
    logic [3:0]  wr_way [16];
    logic [63:0] wb_data [16];
    logic [63:0] mreq_addr [4];
    logic        mreq_we [4];

    always #5 clk_i = ~clk_i;

    // Array model: each word of the victim way holds ARR_BASE + word number.
    assign arr_rdata_i = ARR_BASE + {61'd0, arr_word_o};

    cpu64_l2_line_engine dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_index_i(req_index_i), .req_tag_i(req_tag_i), .req_way_i(req_way_i),
        .done_o(done_o), .wb_done_o(wb_done_o),
        .arr_index_o(arr_index_o), .arr_word_o(arr_word_o), .arr_way_o(arr_way_o),
        .arr_we_o(arr_we_o), .arr_set_valid_o(arr_set_valid_o), .arr_set_dirty_o(arr_set_dirty_o),
        .arr_be_o(arr_be_o), .arr_tag_o(arr_tag_o), .arr_wdata_o(arr_wdata_o),
        .arr_rdata_i(arr_rdata_i), .arr_tag_i(arr_tag_i),
        .arr_valid_i(arr_valid_i), .arr_dirty_i(arr_dirty_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // Runs one miss. Inputs change on the falling edge right after outputs are sampled.
    task automatic do_miss(input logic [7:0] idx, input logic [49:0] tag, input logic [3:0] way,
                           input logic vv, input logic vd, input logic [49:0] vtag,
                           input logic wstall, input logic rgap, input logic stray,
                           input logic hold, input logic abort3);
        int reqw = 0;
        int stall_cnt = 0;
        int n_rd = 0;
        logic rd_phase = 1'b0;
        logic seen = 1'b0;
        logic gap_t = 1'b0;
        logic nr;
        logic [63:0] held = 64'd0;
        n_wr = 0; n_wb = 0; n_mreq = 0; n_done = 0;
        done_wb = 1'b0; post_ok = 1'b0; stall_bad = 1'b0; timed_out = 1'b1;
        @(negedge clk_i);
        arr_tag_i = vtag; arr_valid_i = vv; arr_dirty_i = vd;
        req_index_i = idx; req_tag_i = tag; req_way_i = way; req_valid_i = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            if (hold) req_tag_i = 50'h3FF;
            else      req_valid_i = 1'b0;
            if (arr_we_o) begin
                if (n_wr < 16) begin
                    wr_word[n_wr] = arr_word_o; wr_data[n_wr] = arr_wdata_o;
                    wr_sv[n_wr] = arr_set_valid_o; wr_dirty[n_wr] = arr_set_dirty_o;
                    wr_tag[n_wr] = arr_tag_o; wr_be[n_wr] = arr_be_o;
                    wr_idx[n_wr] = arr_index_o; wr_way[n_wr] = arr_way_o;
                end
                n_wr++;
            end
            if (seen) begin
                post_ok = !done_o && req_ready_o;
                timed_out = 1'b0;
                break;
            end
            if (done_o) begin
                n_done++; done_wb = wb_done_o; seen = 1'b1; req_valid_i = 1'b0;
            end
            if (rd_phase && n_rd < 8) begin
                if (abort3 && n_rd == 3) begin
                    mem_rvalid_i = 1'b0; rst_ni = 1'b0; timed_out = 1'b0;
                    break;
                end
                nr = rgap ? gap_t : 1'b1;
                gap_t = !gap_t;
                mem_rvalid_i = nr;
                mem_rdata_i = RD_BASE + 64'(n_rd);
                if (nr) n_rd++;
            end else begin
                mem_rvalid_i = stray;
                mem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
            end
            if (mem_wvalid_o) begin
                if (wstall && n_wb == 4 && stall_cnt < 3) begin
                    if (stall_cnt > 0 && mem_wdata_o !== held) stall_bad = 1'b1;
                    held = mem_wdata_o; stall_cnt++; mem_wready_i = 1'b0;
                end else begin
                    if (stall_cnt > 0 && n_wb == 4 && mem_wdata_o !== held) stall_bad = 1'b1;
                    mem_wready_i = 1'b1;
                    if (n_wb < 16) wb_data[n_wb] = mem_wdata_o;
                    n_wb++;
                end
            end else begin
                mem_wready_i = stray;
            end
            if (mem_req_valid_o) begin
                if (reqw == 1) begin
                    mem_req_ready_i = 1'b1; reqw = 0;
                    if (n_mreq < 4) begin
                        mreq_addr[n_mreq] = mem_req_addr_o; mreq_we[n_mreq] = mem_req_we_o;
                    end
                    if (!mem_req_we_o) rd_phase = 1'b1;
                    n_mreq++;
                end else begin
                    mem_req_ready_i = 1'b0; reqw++;
                end
            end else begin
                mem_req_ready_i = 1'b0;
            end
        end
        req_valid_i = 1'b0; mem_rvalid_i = 1'b0; mem_wready_i = 1'b0; mem_req_ready_i = 1'b0;
        stalls = stall_cnt;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
        checks++;
        if ({done_o, wb_done_o, arr_we_o, mem_req_valid_o, mem_wvalid_o, arr_set_valid_o} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000",
                {done_o, wb_done_o, arr_we_o, mem_req_valid_o, mem_wvalid_o, arr_set_valid_o});
        end
        checks++;
        if ({mem_req_addr_o, mem_wdata_o, arr_wdata_o, arr_tag_o, arr_index_o, arr_word_o, arr_be_o} !== '0) begin
            failures++; $display("FAIL reset_data got nonzero addr=%h wdata=%h", mem_req_addr_o, arr_wdata_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_clean_victim();
        do_miss(8'h12, 50'h1, 4'h3, 1'b1, 1'b0, 50'h777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL clean_timeout got=timeout exp=done"); end
        checks++; if (n_mreq !== 1) begin failures++; $display("FAIL clean_nreq got=%0d exp=1", n_mreq); end
        checks++;
        if (mreq_we[0] !== 1'b0 || mreq_addr[0] !== 64'h0000_0000_0000_4480) begin
            failures++; $display("FAIL clean_rdreq got=we%b/%h exp=we0/0000000000004480", mreq_we[0], mreq_addr[0]);
        end
        checks++; if (n_wb !== 0) begin failures++; $display("FAIL clean_nwb got=%0d exp=0", n_wb); end
        checks++; if (n_wr !== 8) begin failures++; $display("FAIL clean_nwr got=%0d exp=8", n_wr); end
        for (int k = 0; k < 8 && k < n_wr; k++) begin
            checks++;
            if (wr_word[k] !== 3'(k) || wr_data[k] !== RD_BASE + 64'(k) || wr_sv[k] !== (k == 7)) begin
                failures++; $display("FAIL clean_wr%0d got=w%0d/%h/v%b exp=w%0d/%h/v%b", k,
                    wr_word[k], wr_data[k], wr_sv[k], k, RD_BASE + 64'(k), (k == 7));
            end
            checks++;
            if (wr_tag[k] !== 50'h1 || wr_be[k] !== 8'hFF || wr_dirty[k] !== 1'b0 ||
                wr_idx[k] !== 8'h12 || wr_way[k] !== 4'h3) begin
                failures++; $display("FAIL clean_attr%0d got=tag%h be%h d%b idx%h way%h exp=tag1 beff d0 idx12 way3",
                    k, wr_tag[k], wr_be[k], wr_dirty[k], wr_idx[k], wr_way[k]);
            end
        end
        checks++;
        if (n_done !== 1 || done_wb !== 1'b0 || post_ok !== 1'b1) begin
            failures++; $display("FAIL clean_done got=n%0d wb%b post%b exp=n1 wb0 post1", n_done, done_wb, post_ok);
        end
    endtask

    task automatic test_dirty_victim(input logic stall);
        do_miss(8'h34, 50'h2, 4'h5, 1'b1, 1'b1, 50'hABC, stall, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL dirty_timeout got=timeout exp=done"); end
        checks++;
        if (n_mreq !== 2 || mreq_we[0] !== 1'b1 || mreq_addr[0] !== 64'h0000_0000_02AF_0D00) begin
            failures++; $display("FAIL dirty_wbreq got=n%0d we%b/%h exp=n2 we1/0000000002af0d00",
                n_mreq, mreq_we[0], mreq_addr[0]);
        end
        checks++;
        if (mreq_we[1] !== 1'b0 || mreq_addr[1] !== 64'h0000_0000_0000_8D00) begin
            failures++; $display("FAIL dirty_rdreq got=we%b/%h exp=we0/0000000000008d00", mreq_we[1], mreq_addr[1]);
        end
        checks++; if (n_wb !== 8) begin failures++; $display("FAIL dirty_nwb got=%0d exp=8", n_wb); end
        for (int k = 0; k < 8 && k < n_wb; k++) begin
            checks++;
            if (wb_data[k] !== ARR_BASE + 64'(k)) begin
                failures++; $display("FAIL dirty_wb%0d got=%h exp=%h", k, wb_data[k], ARR_BASE + 64'(k));
            end
        end
        checks++; if (n_wr !== 8) begin failures++; $display("FAIL dirty_nwr got=%0d exp=8", n_wr); end
        checks++;
        if (n_done !== 1 || done_wb !== 1'b1) begin
            failures++; $display("FAIL dirty_done got=n%0d wb%b exp=n1 wb1", n_done, done_wb);
        end
        if (stall) begin
            checks++;
            if (stalls !== 3 || stall_bad !== 1'b0) begin
                failures++; $display("FAIL stall_hold got=stalls%0d unstable%b exp=stalls3 unstable0", stalls, stall_bad);
            end
        end
    endtask

    task automatic test_rvalid_gaps();
        do_miss(8'h01, 50'h10, 4'h1, 1'b1, 1'b0, 50'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (timed_out || mreq_addr[0] !== 64'h0000_0000_0004_0040) begin
            failures++; $display("FAIL gaps_req got=to%b/%h exp=to0/0000000000040040", timed_out, mreq_addr[0]);
        end
        checks++; if (n_wr !== 8) begin failures++; $display("FAIL gaps_nwr got=%0d exp=8", n_wr); end
        for (int k = 0; k < 8 && k < n_wr; k++) begin
            checks++;
            if (wr_word[k] !== 3'(k) || wr_data[k] !== RD_BASE + 64'(k)) begin
                failures++; $display("FAIL gaps_wr%0d got=w%0d/%h exp=w%0d/%h", k, wr_word[k], wr_data[k],
                    k, RD_BASE + 64'(k));
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        int dones = 0;
        do_miss(8'h22, 50'h5, 4'h2, 1'b1, 1'b0, 50'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1 || done_o !== 1'b0 || arr_we_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle got=rdy%b done%b we%b req%b exp=rdy1 done0 we0 req0",
                req_ready_o, done_o, arr_we_o, mem_req_valid_o);
        end
        checks++;
        if (n_wr !== 3 || wr_sv[0] !== 1'b0 || wr_sv[1] !== 1'b0 || wr_sv[2] !== 1'b0) begin
            failures++; $display("FAIL rstmid_partial got=n%0d v%b%b%b exp=n3 v000", n_wr, wr_sv[0], wr_sv[1], wr_sv[2]);
        end
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_nodone got=%0d exp=0", dones); end
    endtask

    task automatic test_invalid_victim();
        do_miss(8'hFF, 50'h3_FFFF_FFFF_FFFF, 4'hF, 1'b0, 1'b1, 50'hABC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (timed_out || n_mreq !== 1 || mreq_we[0] !== 1'b0 || mreq_addr[0] !== 64'hFFFF_FFFF_FFFF_FFC0) begin
            failures++; $display("FAIL inval_req got=to%b n%0d we%b/%h exp=to0 n1 we0/ffffffffffffffc0",
                timed_out, n_mreq, mreq_we[0], mreq_addr[0]);
        end
        checks++;
        if (n_wb !== 0 || done_wb !== 1'b0 || n_done !== 1) begin
            failures++; $display("FAIL inval_nowb got=wb%0d wbdone%b done%0d exp=wb0 wbdone0 done1", n_wb, done_wb, n_done);
        end
        checks++; if (n_wr !== 8) begin failures++; $display("FAIL inval_stray got=%0d writes exp=8", n_wr); end
    endtask

    task automatic test_back_to_back();
        do_miss(8'h56, 50'h7, 4'h6, 1'b1, 1'b0, 50'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (n_mreq !== 1 || mreq_addr[0] !== 64'h0000_0000_0001_D580) begin
            failures++; $display("FAIL busy_req got=n%0d/%h exp=n1/000000000001d580", n_mreq, mreq_addr[0]);
        end
        checks++;
        if (n_wr !== 8 || wr_tag[7] !== 50'h7 || n_done !== 1 || post_ok !== 1'b1) begin
            failures++; $display("FAIL busy_line got=n%0d tag%h done%0d post%b exp=n8 tag7 done1 post1",
                n_wr, wr_tag[7], n_done, post_ok);
        end
    endtask

    initial begin
        test_reset();
        test_clean_victim();
        test_dirty_victim(1'b0);
        test_dirty_victim(1'b1);
        test_rvalid_gaps();
        test_reset_mid_refill();
        test_invalid_victim();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu64_l2_line_engine.md
CPU64_L2_LINE_ENGINE -- requirements
Module: cpu64_l2_line_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- LINE_WORDS, 8, 64-bit beats per 64B line
- TAG_W, 50, tag width
- IDX_W, 8, set index width
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  miss-service request
- req_ready_o  out  1  engine idle, request accepted when both high
- req_index_i  in  IDX_W  set index
- req_tag_i  in  TAG_W  tag of missing line
- req_way_i  in  4  victim way chosen upstream
- done_o  out  1  one-cycle completion pulse
- wb_done_o  out  1  qualifies done_o: a dirty victim was written back
- arr_index_o  out  IDX_W  array set index
- arr_word_o  out  3  array word select
- arr_way_o  out  4  array way select
- arr_we_o  out  1  array write enable
- arr_set_valid_o  out  1  valid bit written
- arr_set_dirty_o  out  1  dirty bit written
- arr_be_o  out  8  byte enables
- arr_tag_o  out  TAG_W  tag written
- arr_wdata_o  out  64  data written
- arr_rdata_i  in  64  selected-way data (combinational)
- arr_tag_i  in  TAG_W  selected-way tag
- arr_valid_i  in  1  selected-way valid
- arr_dirty_i  in  1  selected-way dirty
- mem_req_valid_o  out  1  burst request
- mem_req_ready_i  in  1  burst request accepted
- mem_req_we_o  out  1  1 = write burst, 0 = read burst
- mem_req_addr_o  out  64  line address {tag, index, 6'b0}
- mem_wvalid_o  out  1  write beat valid
- mem_wready_i  in  1  write beat accepted
- mem_wdata_o  out  64  write beat data
- mem_rvalid_i  in  1  read beat valid (no backpressure)
- mem_rdata_i  in  64  read beat data

Function
REQ-003 SHALL implement the FSM states IDLE, PROBE, WB_REQ, WB_DATA, RF_REQ, RF_DATA, DONE.
REQ-004 SHALL assert req_ready_o only in IDLE. On accept it SHALL latch index, tag, and way, then go to PROBE.
REQ-005 PROBE lasts one cycle with arr_way_o/arr_index_o set to the latched values:
- if arr_valid_i and arr_dirty_i: latch arr_tag_i as the victim tag and go to WB_REQ
- otherwise: go to RF_REQ
REQ-006 WB_REQ SHALL hold mem_req_valid_o=1, mem_req_we_o=1, and address {victim tag, index, 6'b0} until mem_req_ready_i, then go to WB_DATA with beat counter 0.
REQ-007 WB_DATA SHALL:
- drive arr_word_o = beat counter, mem_wvalid_o=1, mem_wdata_o = arr_rdata_i
- advance the counter on each mem_wready_i
- after beat 7 is accepted, go to RF_REQ
- never assert arr_we_o
REQ-008 RF_REQ SHALL hold mem_req_valid_o=1, mem_req_we_o=0, and address {req tag, index, 6'b0} until mem_req_ready_i, then go to RF_DATA with beat counter 0.
REQ-009 RF_DATA SHALL, on each mem_rvalid_i:
- assert arr_we_o with arr_be_o=8'hFF, arr_word_o = counter, arr_wdata_o = mem_rdata_i, arr_tag_o = req tag, arr_set_dirty_o=0
- drive arr_set_valid_o=1 only on beat 7; earlier beats write valid=0 so a partial line is never valid
- after beat 7, go to DONE
REQ-010 DONE SHALL pulse done_o for one cycle, with wb_done_o=1 iff a writeback occurred, then return to IDLE.
REQ-011 The beat counter SHALL be 3 bits and SHALL not wrap: the transition is taken on beat 7.
REQ-012 mem_rvalid_i outside RF_DATA and mem_wready_i outside WB_DATA SHALL be ignored.
REQ-013 req_valid_i while busy SHALL be ignored; the requester holds it.
REQ-014 Every output SHALL be registered or a pure decode of state/counter/latches; arr_rdata_i→mem_wdata_o is the only combinational path.

Reset
REQ-015 Asynchronous reset SHALL force IDLE, counter 0, latches 0, and all outputs 0 except req_ready_o=1.
REQ-016 Reset mid-burst SHALL abandon the burst without issuing done_o; a partially refilled line stays invalid per REQ-009.

Structure
REQ-017 LINE_WORDS, TAG_W, IDX_W and the FSM state enum SHALL live in a shared cpu64_l2_pkg.
REQ-018 The block SHALL be a single module with no sub-modules; it instantiates nothing and connects beside cpu64_l2_arrays.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Clean victim (valid=1, dirty=0), index 8'h12, tag 50'h1: one read burst at addr {50'h1, 8'h12, 6'h0}; 8 array writes; only beat 7 has set_valid=1; done_o=1, wb_done_o=0.
- Dirty victim with tag 50'hABC: write burst at {50'hABC, idx, 0} carrying the 8 array words in order, then refill; wb_done_o=1.
- mem_wready_i low for 3 cycles on beat 4: mem_wdata_o held stable, no beat skipped or duplicated.
- Gaps between mem_rvalid_i beats: arr_we_o asserted exactly 8 times, with words 0..7 in order.
- rst_ni low during RF_DATA beat 3: next cycle IDLE, req_ready_o=1, no done_o.
- Invalid victim (valid=0, dirty=1): no writeback performed.
